ones_count_detector: RTL and testbench
======================================

Name: ones_count_detector

Overview:
Parametrised multi-channel ones-counting detector, successor to the fixed 4-count single-input FSM.
- Each of NUM_CH channels counts x=1 samples up to THRESH.
- Per channel: level flag z while the count sits at THRESH, plus a one-cycle hit pulse on each arrival at THRESH.
- Run-time mode selects wrap, sticky or consecutive-only counting; shared en and clr controls.

Parameters:
- THRESH, 4, target count (>=1); z asserts while count==THRESH.
- NUM_CH, 2, number of independent channels (>=1).
- HCW, 8, hit-counter width (used only with HIT_CNT_EN).
- CW (localparam), $clog2(THRESH+1), per-channel count width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample enable; x is ignored when low.
- clr  input  1  synchronous clear of all channel counts; overrides en.
- mode  input  2  0=WRAP, 1=STICKY, 2=CONSEC, 3=reserved (treated as WRAP).
- x  input  NUM_CH  per-channel sample bit.
- z  output  NUM_CH  per channel: (count==THRESH) and not reset; combinational.
- hit  output  NUM_CH  registered one-cycle pulse when count arrives at THRESH.
- count  output  NUM_CH*CW  per-channel count; channel i occupies [i*CW +: CW].
- hit_cnt  output  NUM_CH*HCW  present only with HIT_CNT_EN.

Behaviour:
- Reset (synchronous): count=0, hit=0, hit_cnt=0 on the edge.
- z is forced 0 combinationally while reset=1, including mid-count.
- Priority per cycle: reset > clr > en.
- clr=1: count<=0 and hit<=0 regardless of en or x.
- en=0 (no reset/clr): count holds; hit<=0.
- en=1, per channel, let c = current count:
  - WRAP, x=1: c==THRESH -> 1, else c+1. x=0 -> hold.
  - STICKY, x=1: c==THRESH -> hold, else c+1. x=0 -> hold.
  - CONSEC, x=1: c==THRESH -> 1, else c+1. x=0 -> 0.
- hit <= en & ~clr & x & (next==THRESH) & ~(STICKY & c==THRESH).
  - hit and the z rise appear in the same cycle.
  - THRESH=1 in WRAP/CONSEC: hit fires on every en&x cycle and z stays high.
- Latency: sample at edge k is reflected in count, z and hit after edge k.
- Mode change mid-operation takes effect at the next en cycle; count is not cleared.
  - Example: switching from STICKY with c==THRESH to WRAP gives 1 on the next x=1.
- Count never exceeds THRESH; no overflow is possible.
- Channels are fully independent apart from the shared en, clr and mode.

Optional Feature:
HIT_CNT_EN
- Defined: hit_cnt port exists; a per-channel HCW-bit counter increments on each hit pulse.
  - Saturates at 2^HCW-1.
  - Cleared by reset and clr.
  - Updates in the same cycle hit is registered.
- Undefined: no hit_cnt port and no counter logic; all other behaviour is identical.

Decomposition:
- Package ones_count_pkg: mode encodings MODE_WRAP=2'd0, MODE_STICKY=2'd1, MODE_CONSEC=2'd2, plus the 2-bit mode typedef.
- Sub-module ones_count_ch: one channel (count, next-state, hit, optional hit_cnt), instantiated NUM_CH times in a generate loop.
- Top level: port packing and the reset mask on z.

Test Plan:
1. THRESH=4, WRAP, en=1, x[0]=1 for 5 cycles, x[1]=0:
   - count0 = 1,2,3,4,1; hit0 is a single pulse with count0==4; z0 high that cycle only.
   - count1 stays 0; z1=0.
2. STICKY, x[0]=1 for 6 cycles -> count0 reaches 4 and holds; exactly one hit0 pulse; z0 stays high.
   - Then switch mode to WRAP with x[0]=1 -> count0=1, z0 falls.
3. CONSEC, x[0] = 1,1,0,1,1,1,1 -> count0 = 1,2,0,1,2,3,4; hit0 on the last cycle only.
4. en=0 with x=all-ones for 3 cycles -> counts hold, no hit.
   - clr=1 with en=1, x=1 while count0=3 -> count0=0, hit0=0.
5. Drive count0 to 4 (z0=1), then assert reset:
   - z0 goes 0 in the same cycle (combinational).
   - After the edge: count0=0, hit0=0.
   - Release reset -> counting restarts from 1.
6. With HIT_CNT_EN, HCW=2, THRESH=1, WRAP, x[0]=1 for 5 cycles:
   - hit0 on every cycle; hit_cnt0 = 1,2,3,3,3.
   - clr -> hit_cnt0=0.

Source files
------------

// File: rtl/ones_count_pkg.sv
// Shared mode encodings for the multi-channel ones-counting detector.
package ones_count_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'd0,
        MODE_STICKY = 2'd1,
        MODE_CONSEC = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

endpackage

// File: rtl/ones_count_ch.sv
// One detector channel: saturating/wrapping ones count, arrival pulse and,
// when HIT_CNT_EN is defined, a saturating count of arrival pulses.
module ones_count_ch
    import ones_count_pkg::*;
#(
    parameter int THRESH = 4,
`ifdef HIT_CNT_EN
    parameter int HCW    = 8,
`endif
    parameter int CW     = $clog2(THRESH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  mode_t         mode,
    input  logic          x,
    output logic [CW-1:0] count,
`ifdef HIT_CNT_EN
    output logic [HCW-1:0] hit_cnt,
`endif
    output logic          hit
);

    localparam logic [CW-1:0] TOP = CW'(THRESH);

    logic [CW-1:0] count_nxt;
    logic          full;
    logic          hit_nxt;

    assign full = (count == TOP);

    // Reserved mode falls through to the wrap behaviour.
    always_comb begin
        count_nxt = count;
        if (x) begin
            if (!full) begin
                count_nxt = count + CW'(1);
            end else if (mode != MODE_STICKY) begin
                count_nxt = CW'(1);
            end
        end else if (mode == MODE_CONSEC) begin
            count_nxt = '0;
        end
    end

    // A sticky channel already sitting at the top is not a new arrival.
    assign hit_nxt = x & (count_nxt == TOP) & ~((mode == MODE_STICKY) & full);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
            hit   <= 1'b0;
        end else if (en) begin
            count <= count_nxt;
            hit   <= hit_nxt;
        end else begin
            hit   <= 1'b0;
        end
    end

`ifdef HIT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hit_cnt <= '0;
        end else if (en && hit_nxt && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + HCW'(1);
        end
    end
`endif

endmodule

// File: rtl/ones_count_detector.sv
// Multi-channel ones-counting detector top: packs channel outputs and masks z
// during reset. Optional per-channel hit counters are built with HIT_CNT_EN.
module ones_count_detector
    import ones_count_pkg::*;
#(
    parameter int THRESH = 4,
    parameter int NUM_CH = 2,
    parameter int HCW    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           clr,
    input  logic [1:0]                     mode,
    input  logic [NUM_CH-1:0]              x,
    output logic [NUM_CH-1:0]              z,
    output logic [NUM_CH-1:0]              hit,
`ifdef HIT_CNT_EN
    output logic [NUM_CH*HCW-1:0]          hit_cnt,
`endif
    output logic [NUM_CH*$clog2(THRESH+1)-1:0] count
);

    localparam int CW = $clog2(THRESH + 1);

    if (THRESH < 1 || NUM_CH < 1 || HCW < 1) begin : g_bad_param
        $error("ones_count_detector: THRESH, NUM_CH and HCW must all be >= 1");
    end

    mode_t mode_q;
    assign mode_q = mode_t'(mode);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ones_count_ch #(
            .THRESH (THRESH),
`ifdef HIT_CNT_EN
            .HCW    (HCW),
`endif
            .CW     (CW)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .clr     (clr),
            .mode    (mode_q),
            .x       (x[i]),
            .count   (count[i*CW +: CW]),
`ifdef HIT_CNT_EN
            .hit_cnt (hit_cnt[i*HCW +: HCW]),
`endif
            .hit     (hit[i])
        );

        // z drops the moment reset is asserted, not on the following edge.
        assign z[i] = ~reset & (count[i*CW +: CW] == CW'(THRESH));
    end

endmodule

// File: tb/tb_ones_count_detector.sv
// Bench for ones_count_detector: directed plan steps followed by a random phase,
// all checked against a cycle-level model of the counting rules.
module tb_ones_count_detector;

    localparam int T0   = 4;
    localparam int NCH  = 2;
    localparam int HCW0 = 8;
    localparam int CW0  = $clog2(T0 + 1);
    localparam int T1   = 1;
    localparam int HCW1 = 2;
    localparam int W    = NCH * CW0 + 2 * NCH + 3;

    logic                clk;
    logic                reset, en, clr;
    logic [1:0]          mode;
    logic [NCH-1:0]      x;
    logic [NCH-1:0]      z, hit;
    logic [NCH*CW0-1:0]  count;
    logic                z1, hit1;
    logic [0:0]          count1;
`ifdef HIT_CNT_EN
    logic [NCH*HCW0-1:0] hit_cnt;
    logic [HCW1-1:0]     hit_cnt1;
`endif

    ones_count_detector #(.THRESH(T0), .NUM_CH(NCH), .HCW(HCW0)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode), .x(x),
        .z(z), .hit(hit),
`ifdef HIT_CNT_EN
        .hit_cnt(hit_cnt),
`endif
        .count(count)
    );

    ones_count_detector #(.THRESH(T1), .NUM_CH(1), .HCW(HCW1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode), .x(x[0]),
        .z(z1), .hit(hit1),
`ifdef HIT_CNT_EN
        .hit_cnt(hit_cnt1),
`endif
        .count(count1)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int mc[NCH], mh[NCH], mhc[NCH];
    int mc1, mh1, mhc1;
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // One channel, one enabled cycle: returns new count and whether it is an arrival.
    function automatic void chan_rule(input int c, input bit xi, input int m, input int t,
                                      output int n, output int h);
        bit sticky = (m == 1);
        bit consec = (m == 2);
        if (xi) n = (c == t) ? (sticky ? t : 1) : c + 1;
        else    n = consec ? 0 : c;
        h = (xi && n == t && !(sticky && c == t)) ? 1 : 0;
    endfunction

    task automatic model_step();
        int n, h;
        if (reset || clr) begin
            for (int i = 0; i < NCH; i++) begin mc[i] = 0; mh[i] = 0; mhc[i] = 0; end
            mc1 = 0; mh1 = 0; mhc1 = 0;
        end else if (!en) begin
            for (int i = 0; i < NCH; i++) mh[i] = 0;
            mh1 = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                chan_rule(mc[i], x[i], int'(mode), T0, n, h);
                mc[i] = n; mh[i] = h;
                if (h == 1 && mhc[i] < (1 << HCW0) - 1) mhc[i]++;
            end
            chan_rule(mc1, x[0], int'(mode), T1, n, h);
            mc1 = n; mh1 = h;
            if (h == 1 && mhc1 < (1 << HCW1) - 1) mhc1++;
        end
    endtask

    function automatic logic [W-1:0] pack_expected();
        logic [W-1:0] e;
        e = '0;
        for (int i = 0; i < NCH; i++) begin
            e[i*CW0 +: CW0]      = CW0'(mc[i]);
            e[NCH*CW0 + i]       = (mh[i] == 1);
            e[NCH*CW0 + NCH + i] = !reset && (mc[i] == T0);
        end
        e[W-3] = (mc1 == 1);
        e[W-2] = (mh1 == 1);
        e[W-1] = !reset && (mc1 == T1);
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check({tag, " count"},  32'(count),  32'(e[NCH*CW0-1:0]));
        check({tag, " hit"},    32'(hit),    32'(e[NCH*CW0 +: NCH]));
        check({tag, " z"},      32'(z),      32'(e[NCH*CW0+NCH +: NCH]));
        check({tag, " count1"}, 32'(count1), 32'(e[W-3]));
        check({tag, " hit1"},   32'(hit1),   32'(e[W-2]));
        check({tag, " z1"},     32'(z1),     32'(e[W-1]));
`ifdef HIT_CNT_EN
        for (int i = 0; i < NCH; i++)
            check({tag, " hit_cnt"}, 32'(hit_cnt[i*HCW0 +: HCW0]), 32'(mhc[i]));
        check({tag, " hit_cnt1"}, 32'(hit_cnt1), 32'(mhc1));
`endif
    endtask

    // ---------------- driver ----------------
    task automatic tick(input bit r, input bit e, input bit c, input logic [1:0] m,
                        input logic [NCH-1:0] xv, input string tag);
        reset = r; en = e; clr = c; mode = m; x = xv;
        model_step();
        exp_q.push_back(pack_expected());
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] seq3 [7];
        reset = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'd0; x = '0;
        mc1 = 0; mh1 = 0; mhc1 = 0;
        for (int i = 0; i < NCH; i++) begin mc[i] = 0; mh[i] = 0; mhc[i] = 0; end

        tick(1, 0, 0, 2'd0, 2'b00, "reset");
        tick(1, 1, 0, 2'd0, 2'b11, "reset");
        check("reset count const", 32'(count), 32'd0);

        // Plan 1 (and 6 on dut1): wrap, channel 0 only
        for (int k = 0; k < 5; k++) begin
            tick(0, 1, 0, 2'd0, 2'b01, "wrap");
            if (k == 3) begin
                check("wrap c0 at top", 32'(count[CW0-1:0]), 32'd4);
                check("wrap hit0 at top", 32'(hit[0]), 32'd1);
                check("wrap z0 at top", 32'(z[0]), 32'd1);
            end
        end
        check("wrap c0 wrapped", 32'(count[CW0-1:0]), 32'd1);
        check("wrap c1 idle", 32'(count[2*CW0-1:CW0]), 32'd0);
        check("t1 hit every cycle", 32'(hit1), 32'd1);
`ifdef HIT_CNT_EN
        check("t1 hit_cnt saturated", 32'(hit_cnt1), 32'd3);
`endif

        // Plan 2: sticky holds at top, then wrap restarts from 1
        tick(0, 1, 1, 2'd0, 2'b01, "clr");
`ifdef HIT_CNT_EN
        check("t1 hit_cnt cleared", 32'(hit_cnt1), 32'd0);
`endif
        for (int k = 0; k < 6; k++) tick(0, 1, 0, 2'd1, 2'b01, "sticky");
        check("sticky c0 holds", 32'(count[CW0-1:0]), 32'd4);
        check("sticky no rehit", 32'(hit[0]), 32'd0);
        tick(0, 1, 0, 2'd0, 2'b01, "sticky->wrap");
        check("mode switch c0", 32'(count[CW0-1:0]), 32'd1);
        check("mode switch z0", 32'(z[0]), 32'd0);

        // Plan 3: consecutive-only
        tick(0, 1, 1, 2'd0, 2'b00, "clr");
        seq3 = '{3'd1, 3'd1, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
        for (int k = 0; k < 7; k++) tick(0, 1, 0, 2'd2, {1'b0, seq3[k][0]}, "consec");
        check("consec c0 final", 32'(count[CW0-1:0]), 32'd4);
        check("consec hit0 final", 32'(hit[0]), 32'd1);

        // Plan 4: enable low holds, clr beats en
        for (int k = 0; k < 3; k++) tick(0, 0, 0, 2'd0, 2'b11, "en low");
        check("en low holds c0", 32'(count[CW0-1:0]), 32'd4);
        tick(0, 1, 1, 2'd0, 2'b00, "clr");
        for (int k = 0; k < 3; k++) tick(0, 1, 0, 2'd0, 2'b01, "wrap to 3");
        tick(0, 1, 1, 2'd0, 2'b11, "clr over en");
        check("clr over en c0", 32'(count[CW0-1:0]), 32'd0);
        check("clr over en hit0", 32'(hit[0]), 32'd0);

        // Plan 5: reset masks z combinationally
        for (int k = 0; k < 4; k++) tick(0, 1, 0, 2'd1, 2'b01, "to top");
        check("pre-reset z0", 32'(z[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("reset masks z0", 32'(z[0]), 32'd0);
        tick(1, 1, 0, 2'd1, 2'b01, "reset mid");
        check("reset c0", 32'(count[CW0-1:0]), 32'd0);
        tick(0, 1, 0, 2'd0, 2'b01, "restart");
        check("restart c0", 32'(count[CW0-1:0]), 32'd1);

        // Random phase, including the reserved mode
        for (int k = 0; k < 400; k++) begin
            tick($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)),
                 NCH'($urandom_range(0, (1 << NCH) - 1)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
